// File: rtl/matrix_stream_reducer.sv
// matrix_stream_reducer
// Accepts an N x N matrix as a row-major element stream, accumulates row,
// column, trace and grand-total sums on the fly, then replays the results
// (optionally preceded by the transposed matrix) on a valid/ready output.
module matrix_stream_reducer #(
   parameter int DW     = 8,
   parameter int N      = 4,
   parameter bit SIGNED = 1'b0,
   localparam int LW    = $clog2(N),
   localparam int SW    = DW + 2*LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          mode_tr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] out_data,
   output logic [2:0]    out_tag,
   output logic [LW-1:0] out_idx,
   output logic          out_last,
   output logic          busy
);

   localparam logic [0:0] STATE_LOAD = 1'b0;
   localparam logic [0:0] STATE_EMIT = 1'b1;

   // Result beat counter covers the optional N*N elements plus 2N+2 sums.
   localparam int NB = N*N + 2*N + 2;
   localparam int EW = $clog2(NB);
   localparam logic [EW-1:0] N_E   = EW'(N);
   localparam logic [EW-1:0] N2_E  = EW'(2*N);
   localparam logic [EW-1:0] NN_E  = EW'(N*N);
   localparam logic [LW-1:0] LAST_I = LW'(N-1);

   // Element widened to the sum width; the 2*LW guard bits make every
   // sum of at most N*N elements overflow-free.
   function automatic logic signed [SW-1:0] extend(input logic [DW-1:0] v);
      logic ext_bit;
      ext_bit = SIGNED ? v[DW-1] : 1'b0;
      return {{(SW-DW){ext_bit}}, v};
   endfunction

   logic [0:0]            state;
   logic                  live;
   logic                  mode_lat;
   logic [LW-1:0]         row;
   logic [LW-1:0]         col;
   logic [EW-1:0]         ecnt;
   logic [DW-1:0]         matrix  [N][N];
   logic signed [SW-1:0]  row_sum [N];
   logic signed [SW-1:0]  col_sum [N];
   logic signed [SW-1:0]  trace;
   logic signed [SW-1:0]  total;
   logic signed [SW-1:0]  elem_ext;
   logic                  accept;
   logic                  emit_adv;
   logic                  clear_all;
   logic [EW-1:0]         base;
   logic [EW-1:0]         rel;

   // live holds in_ready low while reset is asserted and releases it on the
   // first clock edge afterwards.
   assign in_ready  = live && (state == STATE_LOAD) && !clr;
   assign accept    = in_valid && in_ready;
   assign emit_adv  = out_valid && out_ready;
   assign clear_all = clr || (emit_adv && out_last);
   assign elem_ext  = extend(in_data);

   // Control and accumulators: load counting, sum update, emit sequencing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= STATE_LOAD;
         live     <= 1'b0;
         mode_lat <= 1'b0;
         busy     <= 1'b0;
         row      <= '0;
         col      <= '0;
         ecnt     <= '0;
         trace    <= '0;
         total    <= '0;
         for (int i = 0; i < N; i++) begin
            row_sum[i] <= '0;
            col_sum[i] <= '0;
         end
      end else begin
         live <= 1'b1;
         if (clear_all) begin
            state <= STATE_LOAD;
            busy  <= 1'b0;
            row   <= '0;
            col   <= '0;
            ecnt  <= '0;
            trace <= '0;
            total <= '0;
            for (int i = 0; i < N; i++) begin
               row_sum[i] <= '0;
               col_sum[i] <= '0;
            end
         end else if (accept) begin
            // The transpose request only counts on the first beat.
            if (row == '0 && col == '0) begin
               mode_lat <= mode_tr;
            end
            busy         <= 1'b1;
            row_sum[row] <= row_sum[row] + elem_ext;
            col_sum[col] <= col_sum[col] + elem_ext;
            total        <= total + elem_ext;
            if (row == col) begin
               trace <= trace + elem_ext;
            end
            col <= col + 1'b1;
            if (col == LAST_I) begin
               row <= row + 1'b1;
               if (row == LAST_I) begin
                  state <= STATE_EMIT;
                  ecnt  <= '0;
               end
            end
         end else if (emit_adv) begin
            ecnt <= ecnt + 1'b1;
         end
      end
   end

   // Element storage; contents are don't-care after a clear or reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         matrix[row][col] <= in_data;
      end
   end

   // Result decode from the beat counter; stable while stalled because
   // neither the counter nor the stored sums move without a handshake.
   always_comb begin
      out_valid = (state == STATE_EMIT);
      out_data  = '0;
      out_tag   = 3'd0;
      out_idx   = '0;
      out_last  = 1'b0;
      base      = mode_lat ? NN_E : '0;
      rel       = ecnt - base;
      if (out_valid) begin
         if (ecnt < base) begin
            // Column-major walk: low bits select the row, high bits the column.
            out_tag  = 3'd0;
            out_idx  = ecnt[LW-1:0];
            out_data = extend(matrix[ecnt[LW-1:0]][ecnt[2*LW-1:LW]]);
         end else if (rel < N_E) begin
            out_tag  = 3'd1;
            out_idx  = rel[LW-1:0];
            out_data = row_sum[rel[LW-1:0]];
         end else if (rel < N2_E) begin
            out_tag  = 3'd2;
            out_idx  = rel[LW-1:0];
            out_data = col_sum[rel[LW-1:0]];
         end else if (rel == N2_E) begin
            out_tag  = 3'd3;
            out_data = trace;
         end else begin
            out_tag  = 3'd4;
            out_data = total;
            out_last = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_matrix_stream_reducer.sv
// Bench for matrix_stream_reducer: an unsigned and a signed instance share
// one stimulus stream and are compared against a queue-based model.
module tb_matrix_stream_reducer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        mode_tr = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        out_ready = 1'b0;

   logic        ir_u, ov_u, ol_u, by_u;
   logic [11:0] od_u;
   logic [2:0]  ot_u;
   logic [1:0]  oi_u;
   logic        ir_s, ov_s, ol_s, by_s;
   logic [11:0] od_s;
   logic [2:0]  ot_s;
   logic [1:0]  oi_s;

   matrix_stream_reducer #(.DW(8), .N(4), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .clr(clr), .mode_tr(mode_tr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir_u),
      .out_valid(ov_u), .out_ready(out_ready), .out_data(od_u),
      .out_tag(ot_u), .out_idx(oi_u), .out_last(ol_u), .busy(by_u)
   );

   matrix_stream_reducer #(.DW(8), .N(4), .SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .clr(clr), .mode_tr(mode_tr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir_s),
      .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
      .out_tag(ot_s), .out_idx(oi_s), .out_last(ol_s), .busy(by_s)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  tag;
      logic [1:0]  idx;
      logic [11:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      int          fill;     // -1: values 1..16, else constant element
      bit          mode;
      int          stall;
      int          beats;
      logic [11:0] trace_u;
      logic [11:0] total_u;
      logic [11:0] trace_s;
      logic [11:0] total_s;
      logic [11:0] row0_s;
   } vec_t;

   beat_t       exp_u[$];
   beat_t       exp_s[$];
   int          checks = 0;
   int          errors = 0;
   int          obs_cnt;
   logic [11:0] obs_trace[2];
   logic [11:0] obs_total[2];
   logic [11:0] obs_row0[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Expected result stream computed directly from the matrix values.
   function automatic void build_exp(input int v[16], input bit mode, input bit sgn);
      int    sv[16];
      int    rs[4];
      int    cs[4];
      int    tr;
      int    tot;
      beat_t b;
      tr = 0;
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         rs[i] = 0;
         cs[i] = 0;
      end
      for (int k = 0; k < 16; k++) begin
         sv[k] = (sgn && v[k] >= 128) ? v[k] - 256 : v[k];
         rs[k / 4] += sv[k];
         cs[k % 4] += sv[k];
         tot += sv[k];
         if (k / 4 == k % 4) tr += sv[k];
      end
      if (mode) begin
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               b = '{tag: 3'd0, idx: 2'(r), data: 12'(sv[r*4+c]), last: 1'b0};
               if (sgn) exp_s.push_back(b); else exp_u.push_back(b);
            end
         end
      end
      for (int r = 0; r < 4; r++) begin
         b = '{tag: 3'd1, idx: 2'(r), data: 12'(rs[r]), last: 1'b0};
         if (sgn) exp_s.push_back(b); else exp_u.push_back(b);
      end
      for (int c = 0; c < 4; c++) begin
         b = '{tag: 3'd2, idx: 2'(c), data: 12'(cs[c]), last: 1'b0};
         if (sgn) exp_s.push_back(b); else exp_u.push_back(b);
      end
      b = '{tag: 3'd3, idx: 2'd0, data: 12'(tr), last: 1'b0};
      if (sgn) exp_s.push_back(b); else exp_u.push_back(b);
      b = '{tag: 3'd4, idx: 2'd0, data: 12'(tot), last: 1'b1};
      if (sgn) exp_s.push_back(b); else exp_u.push_back(b);
   endfunction

   // Drive up to n beats; after a full matrix, step into the first EMIT cycle.
   task automatic feed(input int v[16], input bit mode, input bit gaps, input int n);
      int k = 0;
      int cyc = 0;
      while (k < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = v[k][7:0];
         mode_tr  = (k == 0) ? mode : 1'($urandom_range(0, 1));
         #1;
         if (in_valid && ir_u) k++;
      end
      if (k < n) chk("feed_timeout", k, n);
      if (n == 16) begin
         @(negedge clk);
         in_valid = 1'b0;
         mode_tr  = 1'b0;
         #1;
         chk("emit_latency", ov_u, 1);
         chk("busy_loaded", by_u, 1);
      end
   endtask

   // Drain the result stream, checking order, values and stall stability.
   task automatic collect(input int stall_mode);
      int    cyc = 0;
      int    ph = 0;
      bit    held_v = 0;
      bit    done = 0;
      beat_t held_u, held_s, cur_u, cur_s, want;
      obs_cnt = 0;
      while (!done && cyc < 400) begin
         case (stall_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
         #1;
         if (!ov_u) begin
            chk("out_valid_emit", ov_u, 1);
            done = 1;
         end else begin
            cur_u = '{tag: ot_u, idx: oi_u, data: od_u, last: ol_u};
            cur_s = '{tag: ot_s, idx: oi_s, data: od_s, last: ol_s};
            chk("in_ready_emit", ir_u, 0);
            if (held_v) begin
               chk("stall_hold_u", cur_u, held_u);
               chk("stall_hold_s", cur_s, held_s);
            end
            if (out_ready) begin
               want = (exp_u.size() > 0) ? exp_u.pop_front() : '1;
               chk("beat_u", cur_u, want);
               want = (exp_s.size() > 0) ? exp_s.pop_front() : '1;
               chk("beat_s", cur_s, want);
               obs_cnt++;
               if (cur_u.tag == 3'd3) obs_trace[0] = cur_u.data;
               if (cur_u.tag == 3'd4) obs_total[0] = cur_u.data;
               if (cur_u.tag == 3'd1 && cur_u.idx == 2'd0) obs_row0[0] = cur_u.data;
               if (cur_s.tag == 3'd3) obs_trace[1] = cur_s.data;
               if (cur_s.tag == 3'd4) obs_total[1] = cur_s.data;
               if (cur_s.tag == 3'd1 && cur_s.idx == 2'd0) obs_row0[1] = cur_s.data;
               if (cur_u.last) done = 1;
               held_v = 0;
            end else begin
               held_v = 1;
               held_u = cur_u;
               held_s = cur_s;
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (!done) chk("collect_timeout", cyc, 0);
      out_ready = 1'b0;
      #1;
      chk("idle_out_valid", ov_u, 0);
      chk("idle_in_ready", ir_u, 1);
      chk("idle_busy", by_u, 0);
      chk("left_u", exp_u.size(), 0);
      chk("left_s", exp_s.size(), 0);
   endtask

   task automatic run_matrix(input int v[16], input bit mode, input bit gaps, input int stall);
      exp_u.delete();
      exp_s.delete();
      build_exp(v, mode, 1'b0);
      build_exp(v, mode, 1'b1);
      feed(v, mode, gaps, 16);
      collect(stall);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[4];
      int   seq[16];
      int   vals[16];
      for (int k = 0; k < 16; k++) seq[k] = k + 1;
      tbl[0] = '{fill: -1,   mode: 1'b0, stall: 0, beats: 10, trace_u: 12'd34,  total_u: 12'd136,
                 trace_s: 12'd34,  total_s: 12'd136, row0_s: 12'd10};
      tbl[1] = '{fill: 255,  mode: 1'b0, stall: 0, beats: 10, trace_u: 12'h3FC, total_u: 12'hFF0,
                 trace_s: 12'hFFC, total_s: 12'hFF0, row0_s: 12'hFFC};
      tbl[2] = '{fill: 128,  mode: 1'b0, stall: 0, beats: 10, trace_u: 12'h200, total_u: 12'h800,
                 trace_s: 12'hE00, total_s: 12'h800, row0_s: 12'hE00};
      tbl[3] = '{fill: -1,   mode: 1'b1, stall: 1, beats: 26, trace_u: 12'd34,  total_u: 12'd136,
                 trace_s: 12'd34,  total_s: 12'd136, row0_s: 12'd10};

      // Reset state, held with the clock running.
      #2 rst = 1'b0;
      #15;
      chk("rst_in_ready", ir_u, 0);
      chk("rst_out_valid", ov_u, 0);
      chk("rst_out_data", od_u, 0);
      chk("rst_out_tag", ot_u, 0);
      chk("rst_out_idx", oi_u, 0);
      chk("rst_out_last", ol_u, 0);
      chk("rst_busy", by_u, 0);
      chk("rst_in_ready_s", ir_s, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_in_ready", ir_u, 1);

      // Table-driven scenarios.
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 16; k++) vals[k] = (tbl[t].fill < 0) ? k + 1 : tbl[t].fill;
         @(negedge clk);
         run_matrix(vals, tbl[t].mode, 1'b0, tbl[t].stall);
         chk("tbl_beats", obs_cnt, tbl[t].beats);
         chk("tbl_trace_u", obs_trace[0], tbl[t].trace_u);
         chk("tbl_total_u", obs_total[0], tbl[t].total_u);
         chk("tbl_trace_s", obs_trace[1], tbl[t].trace_s);
         chk("tbl_total_s", obs_total[1], tbl[t].total_s);
         chk("tbl_row0_s", obs_row0[1], tbl[t].row0_s);
      end

      // clr after 7 beats while a beat is offered, then a clean matrix.
      @(negedge clk);
      feed(seq, 1'b0, 1'b0, 7);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd8;
      clr      = 1'b1;
      #1;
      chk("clr_in_ready", ir_u, 0);
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("clr_busy", by_u, 0);
      chk("clr_in_ready_after", ir_u, 1);
      run_matrix(seq, 1'b0, 1'b0, 0);
      chk("clr_total", obs_total[0], 12'd136);
      chk("clr_trace", obs_trace[0], 12'd34);
      chk("clr_beats", obs_cnt, 10);

      // clr during EMIT drops the pending output.
      @(negedge clk);
      feed(seq, 1'b1, 1'b0, 16);
      out_ready = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("clr_emit_out_valid", ov_u, 0);
      chk("clr_emit_in_ready", ir_u, 1);
      chk("clr_emit_busy", by_u, 0);

      // Asynchronous reset mid-EMIT: outputs fall before any clock edge.
      @(negedge clk);
      feed(seq, 1'b0, 1'b0, 16);
      #2 rst = 1'b0;
      #1;
      chk("async_out_valid", ov_u, 0);
      chk("async_out_valid_s", ov_s, 0);
      chk("async_in_ready", ir_u, 0);
      chk("async_out_data", od_u, 0);
      chk("async_busy", by_u, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("async_rel_in_ready", ir_u, 1);
      run_matrix(seq, 1'b0, 1'b0, 0);
      chk("after_rst_total", obs_total[0], 12'd136);

      // Randomized matrices, gaps, modes and back-pressure.
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 16; k++) vals[k] = int'($urandom_range(0, 255));
         @(negedge clk);
         run_matrix(vals, 1'($urandom_range(0, 1)), 1'b1, 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_stream_reducer.md
MATRIX_STREAM_REDUCER -- requirements
Module: matrix_stream_reducer

Interface
REQ-001 SHALL have parameter DW, default 8, meaning element width in bits.
REQ-002 SHALL have parameter N, default 4, meaning matrix dimension (N x N); power of two, N >= 2; LW = log2(N).
REQ-003 SHALL have parameter SIGNED, default 0, meaning elements and sums are two's complement when 1, unsigned when 0.
REQ-004 SHALL derive SW = DW + 2*LW, the width of every output sum.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-007 SHALL have port clr, input, 1 bit, synchronous abort/clear.
REQ-008 SHALL have port mode_tr, input, 1 bit, transpose-readout request, sampled on the first accepted beat of each matrix.
REQ-009 SHALL have ports in_valid (input, 1), in_data (input, DW) and in_ready (output, 1), the element input handshake.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result output handshake.
REQ-011 SHALL have ports out_data (SW), out_tag (3; 0 element, 1 row sum, 2 col sum, 3 trace, 4 total), out_idx (LW), out_last (1) and busy (1), all outputs.

Function
REQ-012 SHALL transfer a beat only in a cycle where valid and ready are both 1 on the same edge.
REQ-013 SHALL implement two states, LOAD and EMIT.
REQ-014 LOAD SHALL drive in_ready = !clr and out_valid = 0, and SHALL write each accepted element to matrix[row][col] in row-major order.
REQ-015 Per accepted beat SHALL: add the element to row_sum[row], col_sum[col] and total, and add it to trace if row == col; col increments and wraps to 0, and row increments when col == N-1.
REQ-016 SHALL extend every element to SW bits before accumulation (sign-extend if SIGNED, else zero-extend), with no overflow possible and no wrap of any sum.
REQ-017 After the N*N-th accepted beat, SHALL enter EMIT on the next edge, with out_valid = 1 in the first cycle after that beat.
REQ-018 EMIT SHALL drive in_ready = 0 and present the result beats in this order:
- if the latched mode_tr = 1: N*N elements in column-major order (tag 0, out_idx = row index, value extended per REQ-016);
- then row_sum[0..N-1] (tag 1);
- then col_sum[0..N-1] (tag 2);
- then trace (tag 3, idx 0);
- then total (tag 4, idx 0, out_last = 1).
REQ-019 out_data, out_tag, out_idx and out_last SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-020 On the out_last handshake SHALL zero all sums, row and col, and return to LOAD; in_ready = 1 in the next cycle.
REQ-021 busy SHALL be 1 from the first accepted beat until the out_last handshake, and 0 otherwise.
REQ-022 clr = 1 in any state SHALL zero all sums, row and col, enter LOAD and drop any pending output on that edge; a beat presented in the same cycle is not accepted. Matrix contents need not be cleared.
REQ-023 mode_tr SHALL be ignored except on the first beat of each matrix.

Reset
REQ-024 While rst = 0, SHALL immediately hold state = LOAD, all sums, row, col and latched mode = 0, out_valid = 0, out_last = 0, busy = 0, out_data = 0, out_tag = 0, out_idx = 0, and in_ready = 0.
REQ-025 After rst deasserts, in_ready SHALL be 1 from the first clk edge; a reset mid-operation discards the partial matrix.

Verification
REQ-026 Scenario: DW=8, N=4, SIGNED=0, mode_tr=0, inputs 1..16, out_ready=1 -> row sums 10,26,42,58; col sums 28,32,36,40; trace 34; total 136 with out_last; 10 output beats, first one cycle after the 16th input.
REQ-027 Scenario: all 16 inputs 0xFF -> each row and col sum 1020, trace 1020, total 4080 (12'hFF0); no wrap.
REQ-028 Scenario: SIGNED=1, all inputs 0x80 -> each row sum 12'hE00 (-512), total 12'h800 (-2048).
REQ-029 Scenario: mode_tr=1 on first beat, inputs 1..16 -> element beats 1,5,9,13,2,6,...,16 with out_idx 0,1,2,3 repeating, then the sums of REQ-026; 26 beats in total.
REQ-030 Scenario: out_ready toggled 1,0,0,1 during EMIT -> no beat lost or duplicated, outputs stable while stalled; in_ready stays 0 until the out_last handshake.
REQ-031 Scenario: clr pulsed after 7 beats with in_valid=1, then inputs 1..16 -> the clr-cycle beat is not accepted and results match REQ-026; also assert rst=0 mid-EMIT -> out_valid falls with no clk edge.
